mux_2_1_rr_arbiter: RTL and testbench

- Upstream control stage for the 2:1 select mux.
- Arbitrates two valid/ready requesters with round-robin fairness and a bounded burst length.
- Drives the mux select line `sel`, holds it stable for the whole burst, and registers the selected data into a one-entry output stage with valid/ready toward the consumer.

---
 rtl/mux_2_1_pkg.sv | 18 +
 rtl/mux_2_1_out_reg.sv | 46 ++++
 rtl/mux_2_1_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_2_1_rr_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mux_2_1_pkg.sv
// Shared definitions for the 2:1 mux round-robin control stage.
package mux_2_1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic SEL_CH0 = 1'b0;
    localparam logic SEL_CH1 = 1'b1;

    // Grant state that corresponds to a channel index.
    function automatic state_t grant_state(input logic ch);
        return (ch == SEL_CH1) ? ST_GRANT1 : ST_GRANT0;
    endfunction

endpackage

// File: rtl/mux_2_1_out_reg.sv
// One-entry valid/ready output register; a drain and a load in the same
// cycle keep the entry full, so one beat per cycle is sustained.
module mux_2_1_out_reg #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    // Next-state of the output entry: load wins over drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/mux_2_1_rr_arbiter.sv
// Round-robin, burst-bounded arbiter driving the 2:1 mux select and feeding
// the selected beat into a one-entry output register.
module mux_2_1_rr_arbiter
    import mux_2_1_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    output logic [1:0]        in_ready,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic              sel,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [CNT_W:0] MAX_BURST_C = (CNT_W+1)'(MAX_BURST);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_grant_q, last_grant_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              can_load_s, xfer_s, own_ch_s, own_valid_s, other_valid_s;
    logic              burst_done_s, grant_req_s, grant_ch_s, go_idle_s;
    logic [CNT_W:0]    cnt_inc_s;
    logic [DATA_W-1:0] sel_data_s;

    assign can_load_s    = ~out_valid | out_ready;
    assign in_ready      = {(state_q == ST_GRANT1) & can_load_s,
                            (state_q == ST_GRANT0) & can_load_s};
    assign xfer_s        = |(in_valid & in_ready);
    assign own_ch_s      = (state_q == ST_GRANT1);
    assign own_valid_s   = in_valid[own_ch_s];
    assign other_valid_s = in_valid[~own_ch_s];
    assign cnt_inc_s     = {1'b0, beat_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    // A saturated counter still counts as "limit reached" so a late competitor wins.
    assign burst_done_s  = (cnt_inc_s >= MAX_BURST_C);
    assign sel_data_s    = (sel_q == SEL_CH1) ? in_data1 : in_data0;

    // Grant decision: which channel (if any) to switch to, or drop to idle.
    always_comb begin
        grant_req_s = 1'b0;
        grant_ch_s  = SEL_CH0;
        go_idle_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid == 2'b11) begin
                    grant_req_s = 1'b1;
                    grant_ch_s  = ~last_grant_q;
                end else if (in_valid == 2'b01) begin
                    grant_req_s = 1'b1;
                    grant_ch_s  = SEL_CH0;
                end else if (in_valid == 2'b10) begin
                    grant_req_s = 1'b1;
                    grant_ch_s  = SEL_CH1;
                end else begin
                    grant_req_s = 1'b0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!own_valid_s) begin
                    if (other_valid_s) begin
                        grant_req_s = 1'b1;
                        grant_ch_s  = ~own_ch_s;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end else if (xfer_s && burst_done_s && other_valid_s) begin
                    grant_req_s = 1'b1;
                    grant_ch_s  = ~own_ch_s;
                end else begin
                    grant_req_s = 1'b0;
                end
            end
            default: go_idle_s = 1'b1;
        endcase
    end

    // Apply the decision to state, select, last grant and burst counter.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        if (grant_req_s) begin
            state_d      = grant_state(grant_ch_s);
            sel_d        = grant_ch_s;
            last_grant_d = grant_ch_s;
            beat_cnt_d   = {CNT_W{1'b0}};
        end else if (go_idle_s) begin
            state_d = ST_IDLE;
        end else if (xfer_s && (cnt_inc_s <= MAX_BURST_C)) begin
            beat_cnt_d = cnt_inc_s[CNT_W-1:0];
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_CH0;
            last_grant_q <= SEL_CH1;
            busy_q       <= 1'b0;
            beat_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;

    mux_2_1_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (xfer_s),
        .load_data (sel_data_s),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_mux_2_1_rr_arbiter.sv
// Scoreboard bench for mux_2_1_rr_arbiter: expected beat order is queued
// per scenario and compared as beats leave the output register.
module tb_mux_2_1_rr_arbiter;

    localparam int DW = 8;

    logic          clk, rst;
    logic [1:0]    in_valid, in_ready;
    logic [DW-1:0] in_data0, in_data1, out_data;
    logic          sel, busy, out_valid, out_ready;

    logic [DW-1:0] src0_q[$];
    logic [DW-1:0] src1_q[$];
    logic [DW-1:0] exp_q[$];

    int  n_cmp = 0;
    int  n_err = 0;
    int  hs0_cnt = 0;
    logic hs0, hs1, hs_prev;

    mux_2_1_rr_arbiter #(.DATA_W(DW), .MAX_BURST(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .sel       (sel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        in_valid[0] = (src0_q.size() != 0);
        in_valid[1] = (src1_q.size() != 0);
        in_data0    = in_valid[0] ? src0_q[0] : 8'h00;
        in_data1    = in_valid[1] ? src1_q[0] : 8'h00;
    endtask

    // One clock: monitor at negedge, advance sources just after posedge.
    task automatic step();
        @(negedge clk);
        if (hs_prev) check_eq("latency", 32'(out_valid), 32'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("sb_extra", 32'(exp_q.size()), 32'd1);
            else check_eq("data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        hs0 = in_valid[0] && in_ready[0];
        hs1 = in_valid[1] && in_ready[1];
        check_eq("rdy_onehot", 32'(in_ready[0] & in_ready[1]), 32'd0);
        @(posedge clk);
        #1;
        if (hs0) begin void'(src0_q.pop_front()); hs0_cnt++; end
        if (hs1) void'(src1_q.pop_front());
        hs_prev = hs0 | hs1;
        drive();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0); i++)
            step();
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; hs_prev = 1'b0;
        in_valid = 2'b00; in_data0 = 8'h00; in_data1 = 8'h00;
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Idle after reset release
        for (int i = 0; i < 4; i++) begin
            check_eq("idle_sel", 32'(sel), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_ov", 32'(out_valid), 32'd0);
            check_eq("idle_rdy", 32'(in_ready), 32'd0);
            step();
        end

        // Channel 1 alone streaming 1,0,1
        src1_q = '{8'h01, 8'h00, 8'h01};
        exp_q  = '{8'h01, 8'h00, 8'h01};
        drive();
        #3 check_eq("ch1_busy_pre", 32'(busy), 32'd0);
        step();
        check_eq("ch1_busy", 32'(busy), 32'd1);
        check_eq("ch1_sel", 32'(sel), 32'd1);
        drain(20);

        // Both channels continuously: 4/4/4 round-robin bursts
        for (int i = 0; i < 8; i++) src0_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) src1_q.push_back(8'(8'h80 + i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h80 + i));
        for (int i = 4; i < 8; i++) exp_q.push_back(8'(i));
        drive();
        drain(40);

        // Backpressure on channel 0
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src0_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        drive();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_ov", 32'(out_valid), 32'd1);
            check_eq("bp_data", 32'(out_data), 32'h10);
            check_eq("bp_rdy", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();
        check_eq("bp_tput", 32'(exp_q.size()), 32'd0);
        drain(20);

        // Channel 0 alone for 20 beats, then channel 1 competes
        hs0_cnt = 0;
        for (int i = 0; i < 30; i++) src0_q.push_back(8'(8'h20 + i));
        for (int i = 0; i < 21; i++) exp_q.push_back(8'(8'h20 + i));
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        for (int i = 21; i < 30; i++) exp_q.push_back(8'(8'h20 + i));
        drive();
        for (int i = 0; i < 100 && hs0_cnt < 20; i++) step();
        check_eq("sat_beats", 32'(hs0_cnt), 32'd20);
        check_eq("sat_cnt", 32'(dut.beat_cnt_q), 32'd4);
        check_eq("sat_sel", 32'(sel), 32'd0);
        check_eq("sat_busy", 32'(busy), 32'd1);
        src1_q.push_back(8'hA0);
        src1_q.push_back(8'hA1);
        drive();
        step();
        step();
        check_eq("sat_switch", 32'(sel), 32'd1);
        drain(60);

        // Asynchronous reset mid-burst with a held beat
        out_ready = 1'b0;
        src1_q = '{8'hE0, 8'hE1};
        drive();
        step();
        step();
        check_eq("pre_rst_sel", 32'(sel), 32'd1);
        check_eq("pre_rst_ov", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_ov", 32'(out_valid), 32'd0);
        check_eq("arst_sel", 32'(sel), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_rdy", 32'(in_ready), 32'd0);
        src0_q.delete(); src1_q.delete(); exp_q.delete();
        hs_prev = 1'b0;
        drive();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        src0_q = '{8'h40, 8'h41};
        src1_q = '{8'hC0};
        exp_q  = '{8'h40, 8'h41, 8'hC0};
        drive();
        step();
        check_eq("post_rst_sel", 32'(sel), 32'd0);
        check_eq("post_rst_busy", 32'(busy), 32'd1);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
